// File: rtl/control_fsm_if.sv
// Bus handshake between the control sequencer and the Avalon-style memory port.
// The sequencer is the master: it issues read/write and observes waitrequest.
interface control_fsm_if;
  logic read;
  logic write;
  logic waitrequest;

  modport master (
    output read,
    output write,
    input  waitrequest
  );

  modport slave (
    input  read,
    input  write,
    output waitrequest
  );
endinterface

// File: rtl/control_fsm.sv
// Multi-cycle MIPS sequencer: walks FETCH/DECODE/EXEC/MEM/WB/MDWAIT, stretches bus phases
// on waitrequest, inserts mult/div stall cycles and halts when the next PC is zero.
module control_fsm #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 8,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  control_fsm_if.master       bus,
  input  logic [5:0]          opcode,
  input  logic [5:0]          function_code,
  input  logic [4:0]          b_code,
  input  logic                pc_next_zero,
  output logic [2:0]          state,
  output logic                ir_write,
  output logic                pc_write,
  output logic                reg_write_enable,
  output logic                hi_wren,
  output logic                lo_wren,
  output logic                multdiv_start,
  output logic                active
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_MDWAIT = 3'd5,
    S_HALT   = 3'd6,
    S_UNUSED = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic is_load, is_store, is_multdiv, is_mult, is_reg_wr, is_mthi, is_mtlo;
  logic [CNT_W-1:0] md_n;

  logic read_c, write_c, ir_write_c, pc_write_c, rwe_c, hi_c, lo_c, mds_c;
  logic complete;

  // Instruction class decode from the IR fields.
  always_comb begin
    is_load    = opcode inside {[6'd32:6'd38]};
    is_store   = opcode inside {6'd40, 6'd41, 6'd43};
    is_multdiv = (opcode == 6'd0) && (function_code inside {[6'd24:6'd27]});
    is_mult    = function_code inside {6'd24, 6'd25};
    is_mthi    = (opcode == 6'd0) && (function_code == 6'd17);
    is_mtlo    = (opcode == 6'd0) && (function_code == 6'd19);
    is_reg_wr  = ((opcode == 6'd0) &&
                  !(function_code inside {6'd8, 6'd17, 6'd19, [6'd24:6'd27]})) ||
                 ((opcode == 6'd1) && (b_code inside {5'd16, 5'd17})) ||
                 (opcode == 6'd3) ||
                 (opcode inside {[6'd9:6'd15]});
    md_n       = is_mult ? MULT_N : DIV_N;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    read_c     = 1'b0;
    write_c    = 1'b0;
    ir_write_c = 1'b0;
    pc_write_c = 1'b0;
    rwe_c      = 1'b0;
    hi_c       = 1'b0;
    lo_c       = 1'b0;
    mds_c      = 1'b0;
    complete   = 1'b0;

    case (state_q)
      S_FETCH: begin
        read_c = 1'b1;
        if (!bus.waitrequest) begin
          ir_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        pc_write_c = 1'b1;
        hi_c       = is_mthi;
        lo_c       = is_mtlo;
        if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (is_multdiv) begin
          mds_c = 1'b1;
          // A zero-cycle unit delivers its result in the start cycle itself.
          if (md_n == '0) begin
            hi_c     = 1'b1;
            lo_c     = 1'b1;
            complete = 1'b1;
          end else begin
            cnt_d   = md_n - CNT_W'(1);
            state_d = S_MDWAIT;
          end
        end else begin
          rwe_c    = is_reg_wr;
          complete = 1'b1;
        end
      end
      S_MEM: begin
        read_c  = is_load;
        write_c = is_store;
        if (!bus.waitrequest) begin
          if (is_load) state_d = S_WB;
          else         complete = 1'b1;
        end
      end
      S_WB: begin
        rwe_c    = 1'b1;
        complete = 1'b1;
      end
      S_MDWAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          hi_c     = 1'b1;
          lo_c     = 1'b1;
          complete = 1'b1;
        end
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase

    if (complete) state_d = pc_next_zero ? S_HALT : S_FETCH;
  end

  // Strobes drop the moment reset is asserted, without waiting for a clock.
  assign bus.read         = read_c     & reset_n;
  assign bus.write        = write_c    & reset_n;
  assign ir_write         = ir_write_c & reset_n;
  assign pc_write         = pc_write_c & reset_n;
  assign reg_write_enable = rwe_c      & reset_n;
  assign hi_wren          = hi_c       & reset_n;
  assign lo_wren          = lo_c       & reset_n;
  assign multdiv_start    = mds_c      & reset_n;
  assign state            = state_q;
  assign active           = (state_q != S_HALT);

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: random instructions with random bus stalls, per-instruction
// strobe/latency totals predicted from the instruction-class rules, plus per-cycle invariants.
module tb_control_fsm;
  localparam int MC = 0;
  localparam int DC = 8;

  typedef struct {
    int cycles; int rd; int wr; int irw; int pcw; int rwe; int hi; int lo; int mds; int halt;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode;
  logic [5:0] function_code;
  logic [4:0] b_code;
  logic       pc_next_zero;
  logic [2:0] state;
  logic       ir_write, pc_write, reg_write_enable, hi_wren, lo_wren, multdiv_start, active;

  control_fsm_if bus();

  exp_t sbq[$];
  int   compared   = 0;
  int   mismatched = 0;
  bit   mon_en     = 1'b0;

  control_fsm #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(8)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .bus              (bus),
    .opcode           (opcode),
    .function_code    (function_code),
    .b_code           (b_code),
    .pc_next_zero     (pc_next_zero),
    .state            (state),
    .ir_write         (ir_write),
    .pc_write         (pc_write),
    .reg_write_enable (reg_write_enable),
    .hi_wren          (hi_wren),
    .lo_wren          (lo_wren),
    .multdiv_start    (multdiv_start),
    .active           (active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected totals for one instruction, from its class and the stalls applied to it.
  function automatic exp_t model(input int op, input int fn, input int bc,
                                 input int fw, input int mw, input int pz);
    exp_t e;
    bit ld, st, md, rw;
    int n;
    ld = (op >= 32 && op <= 38);
    st = (op == 40 || op == 41 || op == 43);
    md = (op == 0 && fn >= 24 && fn <= 27);
    n  = (fn == 24 || fn == 25) ? MC : DC;
    rw = (op == 0 && !(fn == 8 || fn == 17 || fn == 19 || md)) ||
         (op == 1 && (bc == 16 || bc == 17)) || op == 3 || (op >= 9 && op <= 15);
    e.cycles = 3 + fw + (ld ? 2 + mw : 0) + (st ? 1 + mw : 0) + (md ? n : 0);
    e.rd     = 1 + fw + (ld ? 1 + mw : 0);
    e.wr     = st ? 1 + mw : 0;
    e.irw    = 1;
    e.pcw    = 1;
    e.rwe    = (ld || rw) ? 1 : 0;
    e.hi     = ((op == 0 && fn == 17) ? 1 : 0) + (md ? 1 : 0);
    e.lo     = ((op == 0 && fn == 19) ? 1 : 0) + (md ? 1 : 0);
    e.mds    = md ? 1 : 0;
    e.halt   = pz;
    return e;
  endfunction

  // Monitor: totals strobes per instruction and pops the scoreboard at each instruction boundary.
  initial begin
    exp_t acc, e;
    int   prev;
    acc  = '{default: 0};
    prev = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        acc  = '{default: 0};
        prev = 0;
      end else begin
        if ((prev != 0 && state == 3'd0) || (prev != 6 && state == 3'd6)) begin
          if (sbq.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL sb_underflow: got 0 entries, expected 1 at %0t", $time);
          end else begin
            e = sbq.pop_front();
            chk("cycles",        acc.cycles, e.cycles);
            chk("read_cycles",   acc.rd,     e.rd);
            chk("write_cycles",  acc.wr,     e.wr);
            chk("ir_write_cnt",  acc.irw,    e.irw);
            chk("pc_write_cnt",  acc.pcw,    e.pcw);
            chk("reg_write_cnt", acc.rwe,    e.rwe);
            chk("hi_wren_cnt",   acc.hi,     e.hi);
            chk("lo_wren_cnt",   acc.lo,     e.lo);
            chk("md_start_cnt",  acc.mds,    e.mds);
            chk("halted",        int'(state == 3'd6), e.halt);
          end
          acc = '{default: 0};
        end
        if (state == 3'd6) begin
          chk("halt_strobes", int'({bus.read, bus.write, ir_write, pc_write, reg_write_enable,
                                    hi_wren, lo_wren, multdiv_start}), 0);
          chk("halt_active", int'(active), 0);
        end else begin
          acc.cycles++;
          acc.rd  += int'(bus.read);
          acc.wr  += int'(bus.write);
          acc.irw += int'(ir_write);
          acc.pcw += int'(pc_write);
          acc.rwe += int'(reg_write_enable);
          acc.hi  += int'(hi_wren);
          acc.lo  += int'(lo_wren);
          acc.mds += int'(multdiv_start);
          chk("rd_wr_excl",   int'(bus.read && bus.write), 0);
          chk("irw_in_fetch", int'(ir_write && state != 3'd0), 0);
          chk("pcw_in_exec",  int'(pc_write && state != 3'd2), 0);
          chk("run_active",   int'(active), 1);
        end
        prev = int'(state);
      end
    end
  end

  // Drives one instruction from FETCH to its completion; called 2ns after a rising edge.
  task automatic run_instr(input int op, input int fn, input int bc,
                           input int fw, input int mw, input int pz);
    int  fl, ml, n;
    bit  left;
    sbq.push_back(model(op, fn, bc, fw, mw, pz));
    opcode        = 6'(op);
    function_code = 6'(fn);
    b_code        = 5'(bc);
    fl   = fw;
    ml   = mw;
    left = 1'b0;
    for (n = 0; n < 100; n++) begin
      if (left && (state == 3'd0 || state == 3'd6)) break;
      if (state != 3'd0) left = 1'b1;
      case (state)
        3'd0: begin
          bus.waitrequest = (fl > 0);
          if (fl > 0) fl--;
          pc_next_zero = 1'($urandom_range(0, 1));
        end
        3'd1: begin
          bus.waitrequest = 1'($urandom_range(0, 1));
          pc_next_zero    = 1'($urandom_range(0, 1));
        end
        3'd3: begin
          bus.waitrequest = (ml > 0);
          if (ml > 0) ml--;
          pc_next_zero = 1'(pz);
        end
        default: begin
          bus.waitrequest = 1'($urandom_range(0, 1));
          pc_next_zero    = 1'(pz);
        end
      endcase
      @(posedge clk);
      #2;
    end
    if (n == 100) begin
      compared++;
      mismatched++;
      $display("FAIL timeout: got no completion in %0d cycles, expected one (op %0d)", n, op);
    end
  endtask

  task automatic run_random(input int count);
    int op, fn, bc, r;
    for (int i = 0; i < count; i++) begin
      r  = $urandom_range(0, 5);
      op = $urandom_range(0, 63);
      fn = $urandom_range(0, 63);
      bc = $urandom_range(0, 31);
      case (r)
        0: op = 0;
        1: begin op = 0; fn = (i % 2 == 0) ? $urandom_range(24, 27) : $urandom_range(16, 19); end
        2: op = $urandom_range(32, 38);
        3: op = (i % 3 == 0) ? 40 : (i % 3 == 1) ? 41 : 43;
        4: begin op = 1; bc = $urandom_range(15, 18); end
        default: ;
      endcase
      run_instr(op, fn, bc, $urandom_range(0, 2), $urandom_range(0, 2), 0);
    end
  endtask

  task automatic release_reset();
    mon_en          = 1'b0;
    reset_n         = 1'b0;
    bus.waitrequest = 1'b1;
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #2;
    sbq.delete();
    mon_en = 1'b1;
  endtask

  initial begin
    reset_n         = 1'b0;
    opcode          = '0;
    function_code   = '0;
    b_code          = '0;
    pc_next_zero    = 1'b0;
    bus.waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state",  int'(state), 0);
    chk("reset_active", int'(active), 1);
    chk("reset_strobes", int'({bus.read, bus.write, ir_write, pc_write, reg_write_enable,
                               hi_wren, lo_wren, multdiv_start}), 0);

    release_reset();
    run_instr(0, 33, 0, 0, 0, 0);   // ADDU
    run_instr(35, 0, 0, 0, 2, 0);   // LW, two stall cycles in MEM
    run_instr(43, 0, 0, 1, 0, 0);   // SW, one stall cycle in FETCH
    run_instr(0, 26, 0, 0, 0, 0);   // DIV
    run_instr(0, 24, 0, 0, 0, 0);   // MULT with zero stall cycles
    run_instr(0, 17, 0, 0, 0, 0);   // MTHI
    run_instr(0, 19, 0, 1, 0, 0);   // MTLO
    run_instr(1, 0, 16, 0, 0, 0);   // BLTZAL
    run_instr(1, 0, 1, 0, 0, 0);    // BGEZ
    run_instr(2, 0, 0, 0, 0, 0);    // J
    run_instr(63, 0, 0, 0, 0, 0);   // undefined opcode
    run_random(80);
    run_instr(0, 8, 0, 0, 0, 1);    // JR to address zero

    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #2;
      opcode          = 6'($urandom_range(0, 63));
      function_code   = 6'($urandom_range(0, 63));
      bus.waitrequest = 1'($urandom_range(0, 1));
      pc_next_zero    = 1'($urandom_range(0, 1));
    end
    chk("halt_sticky_state", int'(state), 6);
    chk("halt_sticky_active", int'(active), 0);

    // Abort a load stalled in MEM with an asynchronous reset pulse.
    mon_en          = 1'b0;
    reset_n         = 1'b0;
    bus.waitrequest = 1'b1;
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #2;
    opcode          = 6'd35;
    function_code   = 6'd0;
    pc_next_zero    = 1'b0;
    bus.waitrequest = 1'b0;
    for (int i = 0; i < 10 && state != 3'd3; i++) begin
      @(posedge clk);
      #2;
    end
    chk("mem_reached", int'(state), 3);
    bus.waitrequest = 1'b1;
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    chk("mem_read_held", int'(bus.read), 1);
    chk("mem_state_held", int'(state), 3);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_read", int'(bus.read), 0);
    chk("abort_state", int'(state), 0);
    chk("abort_active", int'(active), 1);
    #2 reset_n = 1'b1;
    #1;
    chk("post_abort_state", int'(state), 0);
    chk("post_abort_read", int'(bus.read), 1);
    chk("post_abort_active", int'(active), 1);
    @(posedge clk);
    #2;
    sbq.delete();
    mon_en = 1'b1;

    run_random(20);
    run_instr(35, 0, 0, 1, 1, 1);   // LW completing with next PC zero
    repeat (2) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
- Multi-cycle sequencer for the MIPS CPU. Generates the instruction-phase state internally instead of taking it as an input.
- Stretches fetch and memory phases while the Avalon-style bus holds waitrequest.
- Inserts parametrised stall cycles for MULT/MULTU/DIV/DIVU.
- Halts the core when the next PC is zero.
- Drives the datapath strobes (IR/PC capture, bus read/write, register-file, HI/LO enables) alongside the combinational instruction decoder.

Parameters:
- MULT_CYCLES, 4: stall cycles for MULT/MULTU (funct 24,25) after the EXEC cycle; 0..255.
- DIV_CYCLES, 8: stall cycles for DIV/DIVU (funct 26,27) after the EXEC cycle; 0..255.
- CNT_W, 8: width of the stall counter; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- opcode  in  6  instruction[31:26] from IR; valid from DECODE onward.
- function_code  in  6  instruction[5:0].
- b_code  in  5  instruction[20:16] (REGIMM rt field).
- waitrequest  in  1  bus stall; high means the current read/write has not completed.
- pc_next_zero  in  1  datapath: PC value to be loaded is 0x00000000.
- state  out  3  current state encoding.
- read  out  1  bus read strobe.
- write  out  1  bus write strobe.
- ir_write  out  1  capture readdata into IR.
- pc_write  out  1  update PC.
- reg_write_enable  out  1  register-file write.
- hi_wren, lo_wren  out  1 each  HI/LO write.
- multdiv_start  out  1  one-cycle start pulse to the mult/div unit.
- active  out  1  high until halted.

Behaviour:
- Reset: one clock, asynchronous active-low reset (reset_n).
  - While reset_n is low: state=FETCH (0), counter=0, active=1, all strobes 0.
  - Strobes are Moore/Mealy decode of the state register, gated by reset_n.
- Encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MDWAIT=5, HALT=6; 7 is unused and recovers to HALT.
- Instruction classes:
  - Loads: opcode 32-38.
  - Stores: opcode 40, 41, 43.
  - Multdiv: opcode 0 with funct 24-27.
  - Reg-writing non-memory instructions:
    - opcode 0, except funct 8, 17, 19, 24-27;
    - opcode 1 with b_code 16 or 17;
    - opcode 3, 9-15.
  - Undefined opcodes execute as NOP: PC advances, no write.
- FETCH: read=1.
  - waitrequest=1: hold.
  - waitrequest=0: ir_write=1, next DECODE.
- DECODE: no strobes. Next EXEC.
- EXEC: pc_write=1 for every instruction.
  - hi_wren/lo_wren for MTHI (funct 17) / MTLO (funct 19).
  - Load or store: next MEM.
  - Multdiv with N = MULT_CYCLES or DIV_CYCLES:
    - multdiv_start=1;
    - N=0: hi_wren=lo_wren=1 in this same cycle, then completes;
    - N>0: counter<=N-1, next MDWAIT.
  - Otherwise: reg_write_enable per class, then completes.
- MEM: read=1 (load) or write=1 (store), held stable while waitrequest=1.
  - On waitrequest=0, load: next WB.
  - On waitrequest=0, store: completes.
- WB: reg_write_enable=1, completes.
- MDWAIT:
  - counter != 0: counter decrements, no strobes.
  - counter == 0: hi_wren=lo_wren=1, completes.
- Completion:
  - pc_next_zero=1 sampled in the completing cycle: next HALT.
  - Otherwise: next FETCH.
- HALT: active=0, all strobes 0, sticky until reset.
- Latencies: ALU/branch 3 cycles; store 4; load 5; multdiv 3+N. Each waitrequest-high cycle adds one.
- waitrequest is ignored outside FETCH/MEM.
- Strobes are mutually consistent:
  - never read and write together;
  - ir_write only in FETCH;
  - pc_write only in EXEC.
- Reset asserted mid-instruction (any state, including MEM with waitrequest high) aborts immediately. Strobes drop in the same cycle, asynchronously.

Test Plan:
- Reset release, ADDU (op 0, funct 33), waitrequest=0 -> states 0,1,2,0; ir_write in cycle 0; pc_write and reg_write_enable in cycle 2.
- LW (op 35), waitrequest high 2 cycles in MEM -> read held 3 cycles in MEM; WB asserts reg_write_enable once; total 7 cycles.
- SW (op 43) with waitrequest high 1 cycle in FETCH -> write=1 for 1 cycle in MEM; no reg_write_enable; 5 cycles total.
- DIV (funct 26), DIV_CYCLES=8 -> multdiv_start in EXEC; 8 MDWAIT cycles; hi_wren=lo_wren=1 on the 8th; then FETCH. Repeat with MULT_CYCLES=0 -> HI/LO enables in EXEC.
- JR (funct 8) with pc_next_zero=1 in EXEC -> pc_write=1, no reg_write_enable, next state 6, active=0 thereafter despite waitrequest/opcode activity.
- reset_n pulsed low during MEM of LW with waitrequest=1 -> read drops asynchronously; after release state=0, active=1, read=1.
